// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: bus widths, IO device count and FSM state encodings.
package bus_arbiter_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 12;
    localparam int unsigned MEM_WIDTH      = 8;
    // Upper address bits select the IO device, low 8 bits select the byte.
    localparam int unsigned BUS_IO_NUM     = 2 ** (BUS_ADDR_WIDTH - 8);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAle  = 3'd1,
        StXfer = 3'd2,
        StWait = 3'd3,
        StDone = 3'd4
    } state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester-side and bus-controller-side signals of the bus arbiter.
// The slave modport is the arbiter; the master modport is whoever drives the
// requests and models the bus controller.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_W  = MEM_WIDTH
);

    // Requester side
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic [DATA_W-1:0]         rdata;

    // Bus controller side
    logic                      ale_en;
    logic                      bus_read_en;
    logic                      bus_write_en;
    logic [ADDR_W-1:0]         addr_input;
    logic [DATA_W-1:0]         data_write;
    logic [DATA_W-1:0]         data_read;
    logic                      bus_ready;

    modport master (
        output req, req_we, req_addr, req_wdata, data_read, bus_ready,
        input  gnt, done, err, rdata, ale_en, bus_read_en, bus_write_en, addr_input, data_write
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata, data_read, bus_ready,
        output gnt, done, err, rdata, ale_en, bus_read_en, bus_write_en, addr_input, data_write
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin pick: the first requester at or after last+1 (mod NUM_REQ) wins.
module bus_arbiter_rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan NUM_REQ candidates starting after the previous winner; the last probe is 'last' itself.
    always_comb begin
        winner   = '0;
        win_idx  = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = 32'(last) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any              = 1'b1;
                winner[cand_idx] = 1'b1;
                win_idx          = cand_idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter and transaction sequencer in front of the bus controller.
// Grants one requester at a time, sequences ALE -> strobe -> wait for bus_ready,
// and returns read data or a timeout error. Every output is a register.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_W  = MEM_WIDTH,
    parameter int unsigned TIMEOUT = 15
) (
    input logic          clk,
    input logic          rst,
    bus_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;

    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ale_q, ale_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   data_write_q, data_write_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    bus_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) rr_pick (
        .req     (bus.req),
        .last    (last_q),
        .winner  (pick_onehot),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        done_d       = '0;
        err_d        = '0;
        rdata_d      = '0;
        ale_d        = 1'b0;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        data_write_d = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    gnt_d   = pick_onehot;
                    last_d  = pick_idx;
                    we_d    = bus.req_we[pick_idx];
                    addr_d  = bus.req_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
                    wdata_d = bus.req_wdata[32'(pick_idx) * DATA_W +: DATA_W];
                    ale_d   = 1'b1;
                    state_d = StAle;
                end
            end
            StAle: begin
                wr_en_d      = we_q;
                rd_en_d      = !we_q;
                data_write_d = we_q ? wdata_q : '0;
                state_d      = StXfer;
            end
            StXfer: begin
                if (bus.bus_ready) begin
                    done_d  = gnt_q;
                    rdata_d = we_q ? '0 : bus.data_read;
                    addr_d  = '0;
                    state_d = StDone;
                end else begin
                    cnt_d        = '0;
                    data_write_d = we_q ? wdata_q : '0;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (bus.bus_ready) begin
                    done_d  = gnt_q;
                    rdata_d = we_q ? '0 : bus.data_read;
                    addr_d  = '0;
                    state_d = StDone;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    // Timed out: complete with error and no data.
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    addr_d  = '0;
                    state_d = StDone;
                end else begin
                    cnt_d        = cnt_inc;
                    data_write_d = we_q ? wdata_q : '0;
                end
            end
            StDone: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            gnt_q        <= '0;
            last_q       <= IDX_W'(NUM_REQ - 1);
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            ale_q        <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            data_write_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            ale_q        <= ale_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            data_write_q <= data_write_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.rdata        = rdata_q;
    assign bus.ale_en       = ale_q;
    assign bus.bus_read_en  = rd_en_q;
    assign bus.bus_write_en = wr_en_q;
    assign bus.addr_input   = addr_q;
    assign bus.data_write   = data_write_q;

endmodule
